// File: rtl/gf163_digit_mul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gf163_digit_mul                                               |
// | Purpose  : Digit-serial multiplier over GF(2^163),                       |
// |            f(x) = x^163 + x^7 + x^6 + x^3 + 1.                           |
// |            A is scanned one 2-bit digit per cycle, MSB-first (82 digits, |
// |            A padded with a zero bit 163). Each cycle the 2x163 carry-less|
// |            partial product is folded into a reduced 163-bit accumulator. |
// | Ports    : clk    - rising-edge clock                                    |
// |            rst    - asynchronous active-high reset                       |
// |            start  - request a multiply, sampled only when busy=0         |
// |            op_a   - multiplier A (digit-scanned)                         |
// |            op_b   - multiplicand B                                       |
// |            busy   - high while digits are being processed                |
// |            done   - one-cycle pulse, result valid                        |
// |            result - A*B mod f (the accumulator register)                 |
// | Config   : GF163_MUL_OPREG_EN - when defined, op_a/op_b are captured     |
// |            into internal registers on the accepting edge; otherwise the  |
// |            inputs must be held stable for the whole operation.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gf163_digit_mul (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [162:0] op_a,
  input  logic [162:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [162:0] result
);

  // Index of the most significant digit of the zero-padded 164-bit A.
  localparam logic [6:0] DIGIT_LAST = 7'd81;
  // x^163 folds to x^7+x^6+x^3+1; x^164 folds to x^8+x^7+x^4+x.
  localparam logic [7:0] RED_T163   = 8'hC9;
  localparam logic [8:0] RED_T164   = 9'h192;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [6:0]   cnt;
  logic [162:0] acc;
  logic         accept;   // start taken on this edge
  logic         step;     // process one digit on this edge

  logic [162:0] a_src;
  logic [162:0] b_src;

  // --------------------------------------------------------------------------
  // Operand source: either captured copies or the live inputs.
  // --------------------------------------------------------------------------
`ifdef GF163_MUL_OPREG_EN
  logic [162:0] a_reg;
  logic [162:0] b_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      a_reg <= op_a;
      b_reg <= op_b;
    end
  end

  assign a_src = a_reg;
  assign b_src = b_reg;
`else
  assign a_src = op_a;
  assign b_src = op_b;
`endif

  // --------------------------------------------------------------------------
  // Digit selection: the counter value is the digit index d, so the digit is
  // bits [2d+1:2d] of the padded multiplier.
  // --------------------------------------------------------------------------
  logic [163:0] a_pad;
  logic [7:0]   digit_lsb;
  logic [1:0]   digit;

  assign a_pad     = {1'b0, a_src};
  assign digit_lsb = {cnt, 1'b0};
  assign digit     = a_pad[digit_lsb +: 2];

  // --------------------------------------------------------------------------
  // 2-bit x 163-bit carry-less partial product (164 bits).
  // pp = digit[0]*B XOR digit[1]*(B<<1)
  // --------------------------------------------------------------------------
  logic [163:0] b_lo;
  logic [163:0] b_hi;
  logic [163:0] pp;

  assign b_lo = {1'b0, b_src};
  assign b_hi = {b_src, 1'b0};

  for (genvar i = 0; i < 164; i++) begin : g_pp_bit
    assign pp[i] = (digit[0] & b_lo[i]) ^ (digit[1] & b_hi[i]);
  end

  // --------------------------------------------------------------------------
  // Shift the accumulator by one digit, add the partial product, and fold the
  // two overflow bits back in. The fold terms stay below bit 9, so a single
  // pass fully reduces the sum.
  // --------------------------------------------------------------------------
  logic [164:0] t;
  logic [162:0] fold_163;
  logic [162:0] fold_164;
  logic [162:0] acc_nxt;

  assign t        = {acc, 2'b00} ^ {1'b0, pp};
  assign fold_163 = {163{t[163]}} & {155'd0, RED_T163};
  assign fold_164 = {163{t[164]}} & {154'd0, RED_T164};
  assign acc_nxt  = t[162:0] ^ fold_163 ^ fold_164;

  // --------------------------------------------------------------------------
  // Control FSM: state register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and decoded controls.
  // A start seen in DONE is accepted so back-to-back multiplies have no gap.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == 7'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: accumulator and digit counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= '0;
      cnt <= DIGIT_LAST;
    end else if (step) begin
      acc <= acc_nxt;
      if (cnt != 7'd0) begin
        cnt <= cnt - 7'd1;
      end
    end
  end

  assign result = acc;

endmodule
`default_nettype wire
